// File: rtl/rr_arb_burst_if.sv
// Request/grant bundle between contending masters and the round-robin burst arbiter.
// Handshake: a master raises arb_req[i] and holds it for its whole transfer; it owns the
// resource on every cycle where arb_gnt[i] is 1, and drops arb_req[i] to release it.
interface rr_arb_burst_if #(
    parameter int CH_NUM = 4
);
    localparam int ID_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic              arb_en;
    logic [CH_NUM-1:0] arb_req;
    logic [CH_NUM-1:0] arb_gnt;
    logic [ID_W-1:0]   arb_gnt_id;
    logic              arb_gnt_vld;
    logic              arb_preempt;

    modport master (
        output arb_en, arb_req,
        input  arb_gnt, arb_gnt_id, arb_gnt_vld, arb_preempt
    );

    modport slave (
        input  arb_en, arb_req,
        output arb_gnt, arb_gnt_id, arb_gnt_vld, arb_preempt
    );
endinterface

// File: rtl/rr_arb_burst.sv
// Registered round-robin arbiter with sticky grants and a per-owner burst limit.
// Search starts after the last granted channel; the last owner is always scanned last.
module rr_arb_burst #(
    parameter int CH_NUM    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    rr_arb_burst_if.slave    arb,
    output logic             dbg_state
);
    localparam int ID_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    // With no burst limit the counter simply parks at its maximum value.
    localparam logic [7:0] CNT_SAT = (MAX_BURST == 0) ? 8'hFF : 8'(MAX_BURST);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [CH_NUM-1:0] gnt_q, gnt_d;
    logic              vld_q, vld_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              preempt_q, preempt_d;

    logic              do_grant;
    logic [ID_W-1:0]   win_id;
    logic [CH_NUM-1:0] others;

    function automatic logic [ID_W-1:0] pick(input logic [CH_NUM-1:0] mask,
                                             input logic [ID_W-1:0]   last);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] res;
        logic            found;
        idx   = last;
        res   = last;
        found = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            idx = (idx == ID_W'(CH_NUM - 1)) ? '0 : idx + ID_W'(1);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            vld_q     <= 1'b0;
            gnt_id_q  <= '0;
            last_id_q <= ID_W'(CH_NUM - 1);
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            vld_q     <= vld_d;
            gnt_id_q  <= gnt_id_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        vld_d     = vld_q;
        gnt_id_d  = gnt_id_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        do_grant  = 1'b0;
        // gnt_q is the owner's one-hot while busy, so it doubles as the owner mask.
        others    = arb.arb_req & ~gnt_q;
        win_id    = pick(arb.arb_req, last_id_q);

        case (state_q)
            S_IDLE: begin
                if (arb.arb_en && (|arb.arb_req)) do_grant = 1'b1;
            end
            S_BUSY: begin
                if (!(|(arb.arb_req & gnt_q))) begin
                    if (arb.arb_en && (|arb.arb_req)) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end else if ((MAX_BURST != 0) && (cnt_q == CNT_SAT) &&
                             arb.arb_en && (|others)) begin
                    do_grant  = 1'b1;
                    win_id    = pick(others, last_id_q);
                    preempt_d = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_grant) begin
            state_d   = S_BUSY;
            gnt_d     = CH_NUM'(1) << win_id;
            vld_d     = 1'b1;
            gnt_id_d  = win_id;
            last_id_d = win_id;
            cnt_d     = 8'd1;
        end
    end

    assign arb.arb_gnt     = gnt_q;
    assign arb.arb_gnt_vld = vld_q;
    assign arb.arb_gnt_id  = gnt_id_q;
    assign arb.arb_preempt = preempt_q;
    assign dbg_state       = (state_q == S_BUSY);
endmodule

// File: tb/tb_rr_arb_burst.sv
// Directed and randomized checks of rr_arb_burst (4 channels, burst limit 4) against an
// owner/run-length reference model.
module tb_rr_arb_burst;
    localparam int N    = 4;
    localparam int MAXB = 4;

    logic clk;
    logic rst_n;
    logic dbg_state;

    rr_arb_burst_if #(.CH_NUM(N)) bus ();

    rr_arb_burst #(.CH_NUM(N), .MAX_BURST(MAXB)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .arb       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_owner;   // -1 when nobody holds the grant
    int m_last;
    int m_id;
    int m_len;
    bit m_pre;

    function automatic int win(input int mask, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_id    = 0;
        m_len   = 0;
        m_pre   = 0;
    endtask

    task automatic model_give(input int ch);
        m_owner = ch;
        m_last  = ch;
        m_id    = ch;
        m_len   = 1;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic en);
        int r;
        int oth;
        r     = int'(req);
        m_pre = 0;
        if (m_owner < 0) begin
            if (en && r != 0) model_give(win(r, m_last));
        end else if (!r[m_owner]) begin
            if (en && r != 0) model_give(win(r, m_last));
            else m_owner = -1;
        end else begin
            oth = r & ~(1 << m_owner);
            if (m_len >= MAXB && en && oth != 0) begin
                model_give(win(oth, m_last));
                m_pre = 1;
            end else if (m_len < MAXB) begin
                m_len++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_gnt;
        e_gnt = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        chk("gnt",     32'(bus.arb_gnt),     e_gnt);
        chk("gnt_vld", 32'(bus.arb_gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("gnt_id",  32'(bus.arb_gnt_id),  32'(m_id));
        chk("preempt", 32'(bus.arb_preempt), m_pre ? 32'd1 : 32'd0);
        chk("state",   32'(dbg_state),       (m_owner >= 0) ? 32'd1 : 32'd0);
    endtask

    // driver: inputs change 1 time unit after an edge, outputs checked 1 unit after the next
    task automatic step(input logic [N-1:0] req, input logic en);
        bus.arb_req = req;
        bus.arb_en  = en;
        @(posedge clk);
        model_step(req, en);
        #1;
        check_all();
    endtask

    logic [N-1:0] r_req;

    initial begin
        rst_n       = 1'b0;
        bus.arb_req = '0;
        bus.arb_en  = 1'b0;
        model_reset();
        #12;
        check_all();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // two contenders alternate every burst
        step(4'b1010, 1'b1);
        chk("tp_first_gnt", 32'(bus.arb_gnt), 32'h2);
        for (int i = 0; i < 4; i++) step(4'b1010, 1'b1);
        chk("tp_pre_id3", 32'(bus.arb_gnt_id), 32'd3);
        chk("tp_pre_pulse3", 32'(bus.arb_preempt), 32'd1);
        for (int i = 0; i < 4; i++) step(4'b1010, 1'b1);
        chk("tp_pre_id1", 32'(bus.arb_gnt_id), 32'd1);
        chk("tp_pre_pulse1", 32'(bus.arb_preempt), 32'd1);
        step(4'b0000, 1'b1);

        // lone requester holds indefinitely
        for (int i = 0; i < 50; i++) step(4'b0100, 1'b1);
        chk("tp_single_gnt", 32'(bus.arb_gnt), 32'h4);
        step(4'b0000, 1'b1);

        // owner ch0 releases while ch3 waits: direct handover
        step(4'b0001, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b1000, 1'b1);
        chk("tp_handover", 32'(bus.arb_gnt), 32'h8);
        step(4'b0000, 1'b1);

        // arbitration disabled: no pre-emption, no handover
        step(4'b0010, 1'b1);
        for (int i = 0; i < 8; i++) step(4'b0110, 1'b0);
        chk("tp_en0_hold", 32'(bus.arb_gnt), 32'h2);
        step(4'b0100, 1'b0);
        chk("tp_en0_idle", 32'(bus.arb_gnt_vld), 32'd0);
        step(4'b0100, 1'b1);
        chk("tp_en1_gnt", 32'(bus.arb_gnt), 32'h4);

        // asynchronous reset between edges
        step(4'b1111, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2 rst_n = 1'b1;

        // all requesting from reset: 0,1,2,3,0, four cycles each
        for (int i = 0; i < 17; i++) step(4'b1111, 1'b1);
        chk("tp_wrap_back0", 32'(bus.arb_gnt), 32'h1);
        step(4'b0000, 1'b1);

        // randomized traffic
        r_req = '0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) begin
                if (r_req[c]) begin
                    if ($urandom_range(0, 5) == 0) r_req[c] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r_req[c] = 1'b1;
                end
            end
            step(r_req, ($urandom_range(0, 9) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
